// File: rtl/ngs_boot_gpio_arbiter.sv
// rtl/ngs_boot_gpio_arbiter.sv - two-requester round-robin arbiter in front of a single GPIO register port
module ngs_boot_gpio_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_chipselect,
    output logic              s_write_n,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t              r_state;
    logic                r_grant;
    logic                r_last;
    logic                r_wait0;
    logic                r_wait1;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic                r_rdv0;
    logic                r_rdv1;

    logic                w_req0;
    logic                w_req1;
    logic                w_pick;
    logic                w_issue;
    logic                w_g_write;
    logic [ADDR_W-1:0]   w_g_address;
    logic [DATA_W-1:0]   w_g_writedata;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;
    // On a tie the requester not served last wins; otherwise whoever is pending.
    assign w_pick = (w_req0 && w_req1) ? ~r_last : w_req1;

    // The GPIO side follows the owner's live signals during ISSUE.
    assign w_issue       = (r_state == ISSUE);
    assign w_g_write     = r_grant ? m1_write     : m0_write;
    assign w_g_address   = r_grant ? m1_address   : m0_address;
    assign w_g_writedata = r_grant ? m1_writedata : m0_writedata;

    assign s_chipselect = w_issue;
    assign s_write_n    = ~(w_issue & w_g_write);
    assign s_address    = w_issue ? w_g_address   : '0;
    assign s_writedata  = w_issue ? w_g_writedata : '0;

    assign m0_waitrequest   = r_wait0;
    assign m1_waitrequest   = r_wait1;
    assign m0_readdata      = r_rdata0;
    assign m1_readdata      = r_rdata1;
    assign m0_readdatavalid = r_rdv0;
    assign m1_readdatavalid = r_rdv1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_grant  <= 1'b0;
            r_last   <= 1'b1;
            r_wait0  <= 1'b1;
            r_wait1  <= 1'b1;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_rdv0   <= 1'b0;
            r_rdv1   <= 1'b0;
        end else begin
            r_rdv0 <= 1'b0;
            r_rdv1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req0 || w_req1) begin
                        r_grant <= w_pick;
                        r_wait0 <= w_pick;
                        r_wait1 <= ~w_pick;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_last  <= r_grant;
                    r_wait0 <= 1'b1;
                    r_wait1 <= 1'b1;
                    // A simultaneous read+write is treated as a plain write.
                    r_state <= w_g_write ? IDLE : RESP;
                end
                RESP: begin
                    if (r_grant) begin
                        r_rdata1 <= s_readdata;
                        r_rdv1   <= 1'b1;
                    end else begin
                        r_rdata0 <= s_readdata;
                        r_rdv0   <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ngs_boot_gpio_arbiter.sv
// tb/tb_ngs_boot_gpio_arbiter.sv - directed vector bench for ngs_boot_gpio_arbiter
module tb_ngs_boot_gpio_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, s_writedata, s_readdata;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic        s_chipselect, s_write_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ngs_boot_gpio_arbiter #(.ADDR_W(3), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
        .s_writedata(s_writedata), .s_readdata(s_readdata)
    );

    typedef struct {
        int m0_rd, m0_wr, m0_a, m0_wd;
        int m1_rd, m1_wr, m1_a, m1_wd;
        int srd;
        int e_cs, e_wn, e_a, e_wd;
        int e_w0, e_w1, e_v0, e_v1;
        int e_rd0, e_rd1;
    } vec_t;

    vec_t tbl[20];

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%08h, expected 0x%08h", nm, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        m0_read = 0; m0_write = 0; m0_address = 0; m0_writedata = 0;
        m1_read = 0; m1_write = 0; m1_address = 0; m1_writedata = 0;
        s_readdata = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        @(negedge clk);
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        //          m0 rd wr a wd        m1 rd wr a wd         srd            cs wn a wd          w0 w1 v0 v1  rd0           rd1
        tbl[0]  = '{0, 0, 0, 0,          0, 0, 0, 0,           0,             0, 1, 0, 0,         1, 1, 0, 0,  0,            0};
        tbl[1]  = '{0, 1, 1, 'hFF,       0, 0, 0, 0,           0,             0, 1, 0, 0,         1, 1, 0, 0,  0,            0};
        tbl[2]  = '{0, 1, 1, 'hFF,       0, 0, 0, 0,           0,             1, 0, 1, 'hFF,      0, 1, 0, 0,  0,            0};
        tbl[3]  = '{0, 0, 0, 0,          0, 0, 0, 0,           0,             0, 1, 0, 0,         1, 1, 0, 0,  0,            0};
        tbl[4]  = '{0, 0, 0, 0,          1, 0, 0, 0,           0,             0, 1, 0, 0,         1, 1, 0, 0,  0,            0};
        tbl[5]  = '{0, 0, 0, 0,          1, 0, 0, 0,           0,             1, 1, 0, 0,         1, 0, 0, 0,  0,            0};
        tbl[6]  = '{0, 0, 0, 0,          0, 0, 0, 0,           'h12345678,    0, 1, 0, 0,         1, 1, 0, 0,  0,            0};
        tbl[7]  = '{0, 0, 0, 0,          0, 0, 0, 0,           0,             0, 1, 0, 0,         1, 1, 0, 1,  0,            'h12345678};
        tbl[8]  = '{0, 0, 0, 0,          0, 0, 0, 0,           0,             0, 1, 0, 0,         1, 1, 0, 0,  0,            'h12345678};
        tbl[9]  = '{1, 1, 4, 3,          0, 0, 0, 0,           0,             0, 1, 0, 0,         1, 1, 0, 0,  0,            'h12345678};
        tbl[10] = '{1, 1, 4, 3,          0, 0, 0, 0,           0,             1, 0, 4, 3,         0, 1, 0, 0,  0,            'h12345678};
        tbl[11] = '{0, 0, 0, 0,          0, 0, 0, 0,           0,             0, 1, 0, 0,         1, 1, 0, 0,  0,            'h12345678};
        tbl[12] = '{0, 0, 0, 0,          0, 0, 0, 0,           0,             0, 1, 0, 0,         1, 1, 0, 0,  0,            'h12345678};
        tbl[13] = '{1, 0, 2, 0,          0, 1, 3, 'hAB,        0,             0, 1, 0, 0,         1, 1, 0, 0,  0,            'h12345678};
        tbl[14] = '{1, 0, 2, 0,          0, 1, 3, 'hAB,        0,             1, 0, 3, 'hAB,      1, 0, 0, 0,  0,            'h12345678};
        tbl[15] = '{1, 0, 2, 0,          0, 0, 0, 0,           0,             0, 1, 0, 0,         1, 1, 0, 0,  0,            'h12345678};
        tbl[16] = '{1, 0, 2, 0,          0, 0, 0, 0,           0,             1, 1, 2, 0,         0, 1, 0, 0,  0,            'h12345678};
        tbl[17] = '{0, 0, 0, 0,          0, 0, 0, 0,           'hCAFE0001,    0, 1, 0, 0,         1, 1, 0, 0,  0,            'h12345678};
        tbl[18] = '{0, 0, 0, 0,          0, 0, 0, 0,           0,             0, 1, 0, 0,         1, 1, 1, 0,  'hCAFE0001,   'h12345678};
        tbl[19] = '{0, 0, 0, 0,          0, 0, 0, 0,           0,             0, 1, 0, 0,         1, 1, 0, 0,  'hCAFE0001,   'h12345678};

        reset_n = 0;
        drive_idle();
        repeat (2) @(negedge clk);
        check("rst_cs",  0, 32'(s_chipselect), 0);
        check("rst_wn",  0, 32'(s_write_n), 1);
        check("rst_a",   0, 32'(s_address), 0);
        check("rst_wd",  0, s_writedata, 0);
        check("rst_w0",  0, 32'(m0_waitrequest), 1);
        check("rst_w1",  0, 32'(m1_waitrequest), 1);
        check("rst_v0",  0, 32'(m0_readdatavalid), 0);
        check("rst_v1",  0, 32'(m1_readdatavalid), 0);
        check("rst_rd0", 0, m0_readdata, 0);
        check("rst_rd1", 0, m1_readdata, 0);
        reset_n = 1;

        for (int i = 0; i < 20; i++) begin
            m0_read = tbl[i].m0_rd[0]; m0_write = tbl[i].m0_wr[0];
            m0_address = 3'(tbl[i].m0_a); m0_writedata = tbl[i].m0_wd;
            m1_read = tbl[i].m1_rd[0]; m1_write = tbl[i].m1_wr[0];
            m1_address = 3'(tbl[i].m1_a); m1_writedata = tbl[i].m1_wd;
            s_readdata = tbl[i].srd;
            #1;
            check("cs",  i, 32'(s_chipselect), tbl[i].e_cs);
            check("wn",  i, 32'(s_write_n), tbl[i].e_wn);
            check("a",   i, 32'(s_address), tbl[i].e_a);
            check("wd",  i, s_writedata, tbl[i].e_wd);
            check("w0",  i, 32'(m0_waitrequest), tbl[i].e_w0);
            check("w1",  i, 32'(m1_waitrequest), tbl[i].e_w1);
            check("v0",  i, 32'(m0_readdatavalid), tbl[i].e_v0);
            check("v1",  i, 32'(m1_readdatavalid), tbl[i].e_v1);
            check("rd0", i, m0_readdata, tbl[i].e_rd0);
            check("rd1", i, m1_readdata, tbl[i].e_rd1);
            @(negedge clk);
        end

        // Both requesters write continuously: m0 at cycles 1,5,9; m1 at 3,7,11.
        do_reset();
        m0_write = 1; m0_address = 1; m0_writedata = 'h10;
        m1_write = 1; m1_address = 2; m1_writedata = 'h20;
        for (int c = 0; c < 12; c++) begin
            #1;
            check("rr_w0", c, 32'(m0_waitrequest), (c % 4 == 1) ? 0 : 1);
            check("rr_w1", c, 32'(m1_waitrequest), (c % 4 == 3) ? 0 : 1);
            check("rr_a",  c, 32'(s_address), (c % 4 == 1) ? 1 : ((c % 4 == 3) ? 2 : 0));
            @(negedge clk);
        end

        // Reset pulsed during the RESP cycle of an m0 read.
        do_reset();
        s_readdata = 'hDEAD;
        m0_read = 1; m0_address = 5;
        @(negedge clk);
        #1;
        check("ab_issue_w0", 0, 32'(m0_waitrequest), 0);
        check("ab_issue_cs", 0, 32'(s_chipselect), 1);
        @(negedge clk);
        m0_read = 0; m0_address = 0;
        #1;
        reset_n = 0;
        #1;
        check("ab_rst_v0", 0, 32'(m0_readdatavalid), 0);
        check("ab_rst_w0", 0, 32'(m0_waitrequest), 1);
        check("ab_rst_cs", 0, 32'(s_chipselect), 0);
        check("ab_rst_wn", 0, 32'(s_write_n), 1);
        @(negedge clk);
        reset_n = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("ab_post_v0", c, 32'(m0_readdatavalid), 0);
            check("ab_post_cs", c, 32'(s_chipselect), 0);
            check("ab_post_rd0", c, m0_readdata, 0);
            @(negedge clk);
        end
        s_readdata = 'h55;
        m0_read = 1; m0_address = 1;
        @(negedge clk);
        #1;
        check("ab_new_w0", 0, 32'(m0_waitrequest), 0);
        check("ab_new_a",  0, 32'(s_address), 1);
        @(negedge clk);
        m0_read = 0; m0_address = 0;
        @(negedge clk);
        #1;
        check("ab_new_v0",  0, 32'(m0_readdatavalid), 1);
        check("ab_new_rd0", 0, m0_readdata, 'h55);
        check("ab_new_v1",  0, 32'(m1_readdatavalid), 0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ngs_boot_gpio_arbiter.md
NGS_BOOT_GPIO_ARBITER -- requirements
Module: ngs_boot_gpio_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, meaning the GPIO register address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the data width on both requester and GPIO sides.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mN_address  input  ADDR_W  requester N register address (N = 0, 1; same for REQ-006..011).
REQ-006 SHALL have port mN_read  input  1  requester N read request.
REQ-007 SHALL have port mN_write  input  1  requester N write request.
REQ-008 SHALL have port mN_writedata  input  DATA_W  requester N write data.
REQ-009 SHALL have port mN_waitrequest  output  1  high = request not accepted this cycle.
REQ-010 SHALL have port mN_readdata  output  DATA_W  returned read data.
REQ-011 SHALL have port mN_readdatavalid  output  1  one-cycle pulse qualifying mN_readdata.
REQ-012 SHALL have port s_address  output  ADDR_W  GPIO register address.
REQ-013 SHALL have port s_chipselect  output  1  GPIO select.
REQ-014 SHALL have port s_write_n  output  1  GPIO write strobe, active-low.
REQ-015 SHALL have port s_writedata  output  DATA_W  GPIO write data.
REQ-016 SHALL have port s_readdata  input  DATA_W  GPIO read data, registered by the GPIO one cycle after the address is presented.

Function
REQ-017 SHALL implement the FSM states IDLE, ISSUE and RESP, with a 1-bit register grant (the current owner) and a 1-bit register last (the last requester served).
REQ-018 IDLE: a requester is pending when mN_read or mN_write is high; with one pending, set grant to it and go to ISSUE; with none pending, stay in IDLE.
REQ-019 IDLE with both pending: grant = ~last (round-robin).
REQ-020 ISSUE: drive s_chipselect=1, s_address, s_writedata from the granted requester, s_write_n = ~m_write, and mgrant_waitrequest=0 for exactly this one cycle; update last to grant.
REQ-021 ISSUE exit: go to IDLE when the granted requester is writing; go to RESP when it is reading.
REQ-022 RESP: register s_readdata into mgrant_readdata, pulse mgrant_readdatavalid=1 for one cycle on the following cycle, then go to IDLE.
REQ-023 Latency: write accepted 1 cycle after the request is seen in IDLE; read data valid 3 cycles after the request cycle; throughput is 1 write per 2 cycles or 1 read per 3 cycles.
REQ-024 Outside ISSUE: s_chipselect=0, s_write_n=1, s_address=0, s_writedata=0.
REQ-025 mN_waitrequest SHALL be 1 in every cycle except that requester's ISSUE cycle; requesters hold their request signals while waitrequest is high.
REQ-026 Read and write asserted together by one requester: the write wins, no readdatavalid is produced, and the request is consumed as a single write.
REQ-027 The non-granted requester's readdata/readdatavalid SHALL be unchanged and 0 respectively; readdatavalid SHALL never be high on both requesters in the same cycle.
REQ-028 A request dropped before acceptance: grant is fixed at the IDLE decision; ISSUE executes with whatever the requester presents (protocol violation, no recovery required).

Reset
REQ-029 On reset_n low, asynchronously: state=IDLE, grant=0, last=1 (requester 0 wins the first tie), mN_waitrequest=1, mN_readdatavalid=0, mN_readdata=0, all s_* outputs idle per REQ-024.
REQ-030 Reset asserted during ISSUE or RESP: the transaction is aborted, a pending read returns no readdatavalid, and no GPIO access is issued after release until a new IDLE decision.

Verification
REQ-031 m0 writes addr 1 data 0x0000_00FF alone -> IDLE, then ISSUE: s_chipselect=1, s_write_n=0, s_address=1, s_writedata=0xFF, m0_waitrequest=0 for that cycle only; back to IDLE.
REQ-032 m1 reads addr 0 with the GPIO returning 0x1234_5678 -> m1_readdatavalid=1, m1_readdata=0x12345678 exactly 3 cycles after the request; m0_readdatavalid stays 0.
REQ-033 Both requesters write continuously from the first cycle after reset -> grants alternate m0, m1, m0, m1; each is accepted once per 4 cycles.
REQ-034 m0 read and m1 write asserted in the same cycle after an m0-served transaction -> m1 write issued first, then m0 read; m0 data is valid after m1 completes.
REQ-035 reset_n pulsed low in the RESP cycle of an m0 read -> no m0_readdatavalid, all outputs at reset values, next request served normally.
REQ-036 m0 asserts read=1 and write=1 to addr 4 data 0x3 -> one GPIO write (s_write_n=0) and no readdatavalid.
